lc4_regfile_sb: RTL

Parametrised register file with an integrated per-register pending-write scoreboard, the next generation of the 8x16 LC4 regfile. It provides two read ports, one write port, and issue-time reservation of destination registers. Per-register up/down counters track outstanding producers. It drives source-busy flags and a stall request to the pipelined LC4 decode stage.

---
 rtl/lc4_regfile_pkg.sv | 26 ++
 rtl/lc4_sb_counter.sv | 55 +++++
 rtl/lc4_regfile_sb.sv | 99 +++++++++
 3 files changed

// File: rtl/lc4_regfile_pkg.sv
// Shared constants and width helpers for the LC4 register file
// and its pending-write scoreboard.
package lc4_regfile_pkg;

    localparam int LC4_REG_COUNT = 8;
    localparam int LC4_WORD      = 16;

    // Ceiling log2, at least 1 bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sel_w(input int reg_count);
        return clog2(reg_count);
    endfunction

    function automatic int cnt_w(input int max_pending);
        return clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/lc4_sb_counter.sv
// Saturating up/down pending-write counter for one register,
// with a sticky error flag for overflow/underflow attempts.
module lc4_sb_counter
    import lc4_regfile_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = cnt_w(MAX_PENDING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic             inc,
    input  logic             dec,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Next count: flush wins, inc+dec cancel, ends saturate and flag.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (gwe) begin
            if (flush) begin
                count_d = '0;
            end else if (inc && !dec) begin
                if (count_q == CNT_MAX) err_d = 1'b1;
                else count_d = count_q + CNT_W'(1);
            end else if (dec && !inc) begin
                if (count_q == '0) err_d = 1'b1;
                else count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Count and sticky error state, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/lc4_regfile_sb.sv
// LC4 register file with per-register pending-write scoreboard.
// Optional write-to-read bypass: define LC4_REGFILE_BYPASS_EN.
module lc4_regfile_sb
    import lc4_regfile_pkg::*;
#(
    parameter int n           = LC4_WORD,
    parameter int REG_COUNT   = LC4_REG_COUNT,
    parameter int MAX_PENDING = 3,
    parameter logic [n-1:0] RESET_VALUE = '0,
    localparam int SEL_W = sel_w(REG_COUNT),
    localparam int CNT_W = cnt_w(MAX_PENDING)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gwe,
    input  logic [SEL_W-1:0] i_rs,
    input  logic             i_rs_re,
    output logic [n-1:0]     o_rs_data,
    output logic             o_rs_busy,
    input  logic [SEL_W-1:0] i_rt,
    input  logic             i_rt_re,
    output logic [n-1:0]     o_rt_data,
    output logic             o_rt_busy,
    input  logic [SEL_W-1:0] i_rd,
    input  logic [n-1:0]     i_wdata,
    input  logic             i_rd_we,
    input  logic [SEL_W-1:0] i_issue_rd,
    input  logic             i_issue_we,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_sb_err
);

    logic [n-1:0]     regs_q [REG_COUNT];
    logic [n-1:0]     regs_d [REG_COUNT];
    logic [CNT_W-1:0] cnt    [REG_COUNT];
    logic [REG_COUNT-1:0] err_vec;

    // Next register contents: one write port, gated by gwe.
    always_comb begin
        regs_d = regs_q;
        if (gwe && i_rd_we) regs_d[i_rd] = i_wdata;
    end

    // Register storage with asynchronous reset to RESET_VALUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_sb
        lc4_sb_counter #(
            .MAX_PENDING (MAX_PENDING),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .gwe   (gwe),
            .inc   (i_issue_we && (i_issue_rd == SEL_W'(g))),
            .dec   (i_rd_we && (i_rd == SEL_W'(g))),
            .flush (i_flush),
            .count (cnt[g]),
            .err   (err_vec[g])
        );
    end

    logic [CNT_W-1:0] rs_cnt, rt_cnt;
    assign rs_cnt = cnt[i_rs];
    assign rt_cnt = cnt[i_rt];

`ifdef LC4_REGFILE_BYPASS_EN
    logic rs_hit, rt_hit;
    assign rs_hit = gwe && i_rd_we && (i_rd == i_rs);
    assign rt_hit = gwe && i_rd_we && (i_rd == i_rt);

    // Retiring write forwards its data and its pending slot.
    always_comb begin
        o_rs_data = rs_hit ? i_wdata : regs_q[i_rs];
        o_rt_data = rt_hit ? i_wdata : regs_q[i_rt];
        o_rs_busy = rs_hit ? (rs_cnt > CNT_W'(1)) : (rs_cnt != '0);
        o_rt_busy = rt_hit ? (rt_cnt > CNT_W'(1)) : (rt_cnt != '0);
    end
`else
    // Stored contents only; busy from the raw count.
    always_comb begin
        o_rs_data = regs_q[i_rs];
        o_rt_data = regs_q[i_rt];
        o_rs_busy = (rs_cnt != '0);
        o_rt_busy = (rt_cnt != '0);
    end
`endif

    assign o_stall  = (i_rs_re && o_rs_busy) || (i_rt_re && o_rt_busy);
    assign o_sb_err = |err_vec;

endmodule
